// File: rtl/mux_pkg.sv
// Shared constants and helpers for the arbitrated output mux.
package mux_pkg;

  localparam int ARB_RR    = 0;
  localparam int ARB_FIXED = 1;

  // Ceiling log2 with a floor of 1 so single-bit selects stay legal.
  function automatic int clog2(input int n);
    int r;
    r = 1;
    while ((1 << r) < n) r++;
    return r;
  endfunction

endpackage

// File: rtl/rr_pick.sv
// Wrap-around winner search: first asserted req at or above ptr, as one-hot and index.
module rr_pick
  import mux_pkg::*;
#(
  parameter int NUM_CH = 4,
  parameter int SEL_W  = clog2(NUM_CH)
) (
  input  logic [NUM_CH-1:0] req,
  input  logic [SEL_W-1:0]  ptr,
  output logic [NUM_CH-1:0] grant,
  output logic [SEL_W-1:0]  index
);

  int c;

  // Scan from farthest to nearest so the nearest requester overwrites earlier hits.
  always_comb begin
    grant = '0;
    index = '0;
    c     = 0;
    for (int off = NUM_CH - 1; off >= 0; off--) begin
      c = int'(ptr) + off;
      if (c >= NUM_CH) c = c - NUM_CH;
      if (req[c]) begin
        grant    = '0;
        grant[c] = 1'b1;
        index    = SEL_W'(c);
      end
    end
  end

endmodule

// File: rtl/rr_arb_mux.sv
// N-to-1 arbitrated mux with a single registered output slot (round-robin or fixed priority).
module rr_arb_mux
  import mux_pkg::*;
#(
  parameter int DATA_WIDTH = 32,
  parameter int NUM_CH     = 4,
  parameter int ARB_MODE   = ARB_RR
) (
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic [NUM_CH*DATA_WIDTH-1:0] in_data,
  input  logic [NUM_CH-1:0]            in_valid,
  output logic [NUM_CH-1:0]            in_ready,
  output logic [DATA_WIDTH-1:0]        out_data,
  output logic                         out_valid,
  input  logic                         out_ready,
  output logic [clog2(NUM_CH)-1:0]     out_sel
);

  localparam int SEL_W = clog2(NUM_CH);
  localparam logic [SEL_W-1:0] LastCh = SEL_W'(NUM_CH - 1);

  logic                  out_valid_q, out_valid_d;
  logic [DATA_WIDTH-1:0] out_data_q, out_data_d;
  logic [SEL_W-1:0]      out_sel_q, out_sel_d;
  logic [SEL_W-1:0]      ptr_q, ptr_d;

  logic [NUM_CH-1:0]     pick_grant;
  logic [SEL_W-1:0]      pick_idx;
  logic [SEL_W-1:0]      pick_ptr;
  logic                  can_load;
  logic                  xfer;
  logic [DATA_WIDTH-1:0] ch_data [NUM_CH];

  for (genvar i = 0; i < NUM_CH; i++) begin : g_unpack
    assign ch_data[i] = in_data[i*DATA_WIDTH +: DATA_WIDTH];
  end

  // Fixed priority is the same search anchored at channel 0.
  assign pick_ptr = (ARB_MODE == ARB_FIXED) ? '0 : ptr_q;

  rr_pick #(
    .NUM_CH (NUM_CH),
    .SEL_W  (SEL_W)
  ) u_pick (
    .req   (in_valid),
    .ptr   (pick_ptr),
    .grant (pick_grant),
    .index (pick_idx)
  );

  // Gating with rst_n forces in_ready low during reset without waiting for a clock.
  assign can_load = rst_n && (!out_valid_q || out_ready);
  assign in_ready = can_load ? pick_grant : '0;
  assign xfer     = |(in_valid & in_ready);

  always_comb begin
    out_valid_d = out_valid_q;
    out_data_d  = out_data_q;
    out_sel_d   = out_sel_q;
    ptr_d       = ptr_q;
    if (xfer) begin
      out_valid_d = 1'b1;
      out_data_d  = ch_data[pick_idx];
      out_sel_d   = pick_idx;
      if (ARB_MODE != ARB_FIXED) begin
        ptr_d = (pick_idx == LastCh) ? '0 : pick_idx + 1'b1;
      end
    end else if (out_ready) begin
      out_valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid_q <= 1'b0;
      out_data_q  <= '0;
      out_sel_q   <= '0;
      ptr_q       <= '0;
    end else begin
      out_valid_q <= out_valid_d;
      out_data_q  <= out_data_d;
      out_sel_q   <= out_sel_d;
      ptr_q       <= ptr_d;
    end
  end

  assign out_valid = out_valid_q;
  assign out_data  = out_data_q;
  assign out_sel   = out_sel_q;

endmodule

// File: tb/tb_rr_arb_mux.sv
// Directed bench: a round-robin instance and a fixed-priority instance side by side.
module tb_rr_arb_mux;

  logic         clk = 1'b0;
  logic         rst_n;
  logic [127:0] in_data;
  logic [3:0]   in_valid, in_ready, f_in_valid, f_in_ready;
  logic [31:0]  out_data, f_out_data;
  logic         out_valid, out_ready, f_out_valid, f_out_ready;
  logic [1:0]   out_sel, f_out_sel;

  int n_cmp = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  rr_arb_mux #(.DATA_WIDTH(32), .NUM_CH(4), .ARB_MODE(0)) u_rr (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_data   (in_data),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .out_data  (out_data),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_sel   (out_sel)
  );

  rr_arb_mux #(.DATA_WIDTH(32), .NUM_CH(4), .ARB_MODE(1)) u_fx (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_data   (in_data),
    .in_valid  (f_in_valid),
    .in_ready  (f_in_ready),
    .out_data  (f_out_data),
    .out_valid (f_out_valid),
    .out_ready (f_out_ready),
    .out_sel   (f_out_sel)
  );

  task automatic step();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    in_valid = 4'hF; f_in_valid = 4'h0; out_ready = 1'b1; f_out_ready = 1'b1;
    for (int i = 0; i < 4; i++) in_data[i*32 +: 32] = 32'h1000_0000 + i;
    @(posedge clk); #1;
    n_cmp++; if (in_ready !== 4'b0000) begin n_err++;
      $display("FAIL reset_in_ready got %b want 0000", in_ready); end
    n_cmp++; if (out_valid !== 1'b0) begin n_err++;
      $display("FAIL reset_out_valid got %b want 0", out_valid); end
    n_cmp++; if (out_sel !== 2'd0) begin n_err++;
      $display("FAIL reset_out_sel got %0d want 0", out_sel); end
    n_cmp++; if (out_data !== 32'h0) begin n_err++;
      $display("FAIL reset_out_data got %h want 0", out_data); end
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic test_fairness();
    for (int k = 0; k < 5; k++) begin
      #1;
      n_cmp++; if (in_ready !== (4'b0001 << (k % 4))) begin n_err++;
        $display("FAIL rr_in_ready[%0d] got %b want %b", k, in_ready, 4'b0001 << (k % 4)); end
      step();
      n_cmp++; if (out_valid !== 1'b1 || out_sel !== 2'(k % 4)) begin n_err++;
        $display("FAIL rr_sel[%0d] got v=%b sel=%0d want v=1 sel=%0d", k, out_valid, out_sel,
                 k % 4); end
      n_cmp++; if (out_data !== 32'h1000_0000 + (k % 4)) begin n_err++;
        $display("FAIL rr_data[%0d] got %h want %h", k, out_data, 32'h1000_0000 + (k % 4)); end
    end
  endtask

  task automatic test_wrap_skip();
    in_valid = 4'b0100;  // ptr 1 -> grant 2 -> ptr 3
    step();
    n_cmp++; if (out_sel !== 2'd2) begin n_err++;
      $display("FAIL setup_ptr3 got sel=%0d want 2", out_sel); end
    in_valid = 4'b0101; #1;
    n_cmp++; if (in_ready !== 4'b0001) begin n_err++;
      $display("FAIL wrap_grant got %b want 0001", in_ready); end
    step();
    n_cmp++; if (out_sel !== 2'd0) begin n_err++;
      $display("FAIL wrap_sel got %0d want 0", out_sel); end
    #1;
    n_cmp++; if (in_ready !== 4'b0100) begin n_err++;
      $display("FAIL skip_grant got %b want 0100", in_ready); end
    step();
    n_cmp++; if (out_sel !== 2'd2) begin n_err++;
      $display("FAIL skip_sel got %0d want 2", out_sel); end
    in_valid = 4'b1001; #1;
    n_cmp++; if (in_ready !== 4'b1000) begin n_err++;
      $display("FAIL ptr_is_3 got %b want 1000", in_ready); end
    step();
    n_cmp++; if (out_sel !== 2'd3) begin n_err++;
      $display("FAIL ptr3_sel got %0d want 3", out_sel); end
  endtask

  task automatic test_backpressure();
    in_data[32 +: 32] = 32'hA5A5_A5A5;
    in_valid = 4'b0010;  // ptr 0 -> grant 1 -> ptr 2
    step();
    n_cmp++; if (out_sel !== 2'd1 || out_data !== 32'hA5A5_A5A5) begin n_err++;
      $display("FAIL bp_load got sel=%0d data=%h want 1/a5a5a5a5", out_sel, out_data); end
    out_ready = 1'b0; in_valid = 4'hF; in_data[32 +: 32] = 32'hDEAD_BEEF;
    for (int k = 0; k < 5; k++) begin
      #1;
      n_cmp++; if (in_ready !== 4'b0000) begin n_err++;
        $display("FAIL bp_in_ready[%0d] got %b want 0000", k, in_ready); end
      step();
      n_cmp++; if (out_valid !== 1'b1 || out_sel !== 2'd1 || out_data !== 32'hA5A5_A5A5) begin
        n_err++;
        $display("FAIL bp_hold[%0d] got v=%b sel=%0d data=%h want 1/1/a5a5a5a5", k, out_valid,
                 out_sel, out_data); end
    end
    out_ready = 1'b1; #1;
    n_cmp++; if (in_ready !== 4'b0100) begin n_err++;
      $display("FAIL bp_ptr_kept got %b want 0100", in_ready); end
    step();
    n_cmp++; if (out_sel !== 2'd2) begin n_err++;
      $display("FAIL bp_release_sel got %0d want 2", out_sel); end
    in_data[32 +: 32] = 32'h1000_0001;
  endtask

  task automatic test_drain_refill();
    in_valid = 4'b0000;
    step();
    n_cmp++; if (out_valid !== 1'b0 || in_ready !== 4'b0000) begin n_err++;
      $display("FAIL drain got v=%b rdy=%b want 0/0000", out_valid, in_ready); end
    in_data[64 +: 32] = 32'h1234_5678;
    in_valid = 4'b0100; #1;
    n_cmp++; if (in_ready !== 4'b0100) begin n_err++;
      $display("FAIL refill_grant got %b want 0100", in_ready); end
    step();
    n_cmp++; if (out_valid !== 1'b1 || out_sel !== 2'd2 || out_data !== 32'h1234_5678) begin
      n_err++;
      $display("FAIL refill got v=%b sel=%0d data=%h want 1/2/12345678", out_valid, out_sel,
               out_data); end
    in_valid = 4'b0000;
    step();
    n_cmp++; if (out_valid !== 1'b0) begin n_err++;
      $display("FAIL redrain got v=%b want 0", out_valid); end
  endtask

  task automatic test_fixed();
    f_in_valid = 4'b1010;
    for (int k = 0; k < 6; k++) begin
      #1;
      n_cmp++; if (f_in_ready !== 4'b0010) begin n_err++;
        $display("FAIL fx_grant[%0d] got %b want 0010", k, f_in_ready); end
      step();
      n_cmp++; if (f_out_valid !== 1'b1 || f_out_sel !== 2'd1 || f_out_data !== 32'h1000_0001)
      begin
        n_err++;
        $display("FAIL fx_out[%0d] got v=%b sel=%0d data=%h want 1/1/10000001", k, f_out_valid,
                 f_out_sel, f_out_data); end
    end
    f_in_valid = 4'b0000;
  endtask

  task automatic test_reset_mid();
    in_valid = 4'b1000; out_ready = 1'b0;
    step();
    n_cmp++; if (out_valid !== 1'b1 || out_sel !== 2'd3) begin n_err++;
      $display("FAIL mid_setup got v=%b sel=%0d want 1/3", out_valid, out_sel); end
    out_ready = 1'b1; #2;
    rst_n = 1'b0; #1;
    n_cmp++; if (out_valid !== 1'b0 || out_sel !== 2'd0 || out_data !== 32'h0) begin n_err++;
      $display("FAIL mid_reset got v=%b sel=%0d data=%h want 0/0/0", out_valid, out_sel,
               out_data); end
    n_cmp++; if (in_ready !== 4'b0000) begin n_err++;
      $display("FAIL mid_reset_rdy got %b want 0000", in_ready); end
    in_valid = 4'hF;
    @(negedge clk);
    rst_n = 1'b1; #1;
    n_cmp++; if (in_ready !== 4'b0001) begin n_err++;
      $display("FAIL post_reset_ptr got %b want 0001", in_ready); end
    step();
    n_cmp++; if (out_valid !== 1'b1 || out_sel !== 2'd0) begin n_err++;
      $display("FAIL first_xfer got v=%b sel=%0d want 1/0", out_valid, out_sel); end
  endtask

  initial begin
    test_reset();
    test_fairness();
    test_wrap_skip();
    test_backpressure();
    test_drain_refill();
    test_fixed();
    test_reset_mid();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
